// File: rtl/game_pkg.sv
// Shared definitions for the game-flow controller: state encoding, RGB444 colours
// and the per-state colour selection used for the VGA output register.
package game_pkg;

    typedef enum logic [2:0] {
        INITIAL  = 3'd0,
        RUNNING  = 3'd1,
        OVER     = 3'd2,
        SUCCESS  = 3'd3,
        DYING    = 3'd4,
        LEVEL_UP = 3'd5,
        PAUSED   = 3'd6
    } game_state_e;

    localparam logic [11:0] COLOR_RED   = 12'hF00;
    localparam logic [11:0] COLOR_GREEN = 12'h0F0;
    localparam logic [11:0] COLOR_BLUE  = 12'h00F;
    localparam logic [11:0] COLOR_WHITE = 12'hFFF;
    localparam logic [11:0] COLOR_BLACK = 12'h000;

    // Halves each RGB nibble independently so no channel bleeds into its neighbour.
    function automatic logic [11:0] dim_color(logic [11:0] c);
        return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
    endfunction

    function automatic logic [11:0] state_color(game_state_e st, logic blink, logic [11:0] bg);
        logic [11:0] c;
        c = COLOR_BLACK;
        case (st)
            INITIAL:  c = COLOR_RED;
            RUNNING:  c = bg;
            DYING:    c = blink ? COLOR_WHITE : bg;
            LEVEL_UP: c = COLOR_GREEN;
            OVER:     c = COLOR_BLACK;
            SUCCESS:  c = COLOR_BLUE;
            PAUSED:   c = dim_color(bg);
            default:  c = COLOR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Event/status bundle between input+collision logic (master) and the game-flow controller (slave).
interface game_flow_ctrl_if;
    import game_pkg::*;

    logic        frame_tick;
    logic        start;
    logic        restart;
    logic        die;
    logic        level_done;
    logic        pause_btn;
    logic [11:0] bg_color;
    logic [2:0]  state;
    logic [3:0]  lives;
    logic [3:0]  level;
    logic        splash;
    logic [11:0] vga_data;

    modport master (
        output frame_tick, start, restart, die, level_done, pause_btn, bg_color,
        input  state, lives, level, splash, vga_data
    );

    modport slave (
        input  frame_tick, start, restart, die, level_done, pause_btn, bg_color,
        output state, lives, level, splash, vga_data
    );

endinterface

// File: rtl/frame_timer.sv
// Frame-tick counter with synchronous clear; tc pulses on the tick that completes FRAMES ticks,
// and the count wraps to zero on that same tick.
module frame_timer #(
    parameter int FRAMES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic tc
);
    localparam int W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    logic [W-1:0] cnt;

    assign tc = tick && !clr && (cnt == W'(FRAMES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: lives/level tracking, frame-timed splash screens, registered VGA colour.
// Optional pause state is built when GAME_PAUSE_EN is defined.
//
// state    | meaning
// INITIAL  | title screen, waiting for start
// RUNNING  | gameplay, bg_color shown
// DYING    | player hit, blinking splash for SPLASH_FRAMES frames
// LEVEL_UP | level cleared, green splash for SPLASH_FRAMES frames
// OVER     | no lives left, terminal until restart
// SUCCESS  | last level cleared, terminal until restart
// PAUSED   | gameplay frozen, dimmed background (GAME_PAUSE_EN only)
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int LIVES         = 3,
    parameter int LEVELS        = 4,
    parameter int SPLASH_FRAMES = 120,
    parameter int BLINK_FRAMES  = 8
) (
    input logic             clk,
    input logic             rst,
    game_flow_ctrl_if.slave bus
);
    game_state_e state_q;
    logic [3:0]  lives_q;
    logic [3:0]  level_q;
    logic [11:0] vga_q;
    logic        blink_q;

    logic        in_splash;
    logic        splash_clr;
    logic        splash_tc;
    logic        blink_clr;
    logic        blink_tc;

    assign in_splash  = (state_q == DYING) || (state_q == LEVEL_UP);
    // Clearing while outside the splash states also discards a tick on the entry cycle.
    assign splash_clr = bus.restart || !in_splash;
    assign blink_clr  = bus.restart || (state_q != DYING);

    frame_timer #(.FRAMES(SPLASH_FRAMES)) u_splash_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (splash_clr),
        .tick (bus.frame_tick),
        .tc   (splash_tc)
    );

    frame_timer #(.FRAMES(BLINK_FRAMES)) u_blink_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (blink_clr),
        .tick (bus.frame_tick),
        .tc   (blink_tc)
    );

`ifndef GAME_PAUSE_EN
    logic unused_pause_btn;
    assign unused_pause_btn = bus.pause_btn;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INITIAL;
            lives_q <= 4'(LIVES);
            level_q <= '0;
            vga_q   <= COLOR_BLACK;
            blink_q <= 1'b0;
        end else begin
            vga_q <= state_color(state_q, blink_q, bus.bg_color);

            if (blink_clr) begin
                blink_q <= 1'b0;
            end else if (blink_tc) begin
                blink_q <= ~blink_q;
            end

            if (bus.restart) begin
                state_q <= INITIAL;
                lives_q <= 4'(LIVES);
                level_q <= '0;
            end else begin
                case (state_q)
                    INITIAL: begin
                        if (bus.start) state_q <= RUNNING;
                    end
                    RUNNING: begin
                        if (bus.die) begin
                            if (lives_q > 4'd1) begin
                                lives_q <= lives_q - 4'd1;
                                state_q <= DYING;
                            end else begin
                                lives_q <= '0;
                                state_q <= OVER;
                            end
                        end else if (bus.level_done) begin
                            if (level_q < 4'(LEVELS - 1)) begin
                                level_q <= level_q + 4'd1;
                                state_q <= LEVEL_UP;
                            end else begin
                                state_q <= SUCCESS;
                            end
`ifdef GAME_PAUSE_EN
                        end else if (bus.pause_btn) begin
                            state_q <= PAUSED;
`endif
                        end
                    end
                    DYING, LEVEL_UP: begin
                        if (splash_tc) state_q <= RUNNING;
                    end
                    OVER, SUCCESS: begin
                        state_q <= state_q;
                    end
`ifdef GAME_PAUSE_EN
                    PAUSED: begin
                        if (bus.pause_btn) state_q <= RUNNING;
                    end
`endif
                    default: state_q <= INITIAL;
                endcase
            end
        end
    end

    assign bus.state    = state_q;
    assign bus.lives    = lives_q;
    assign bus.level    = level_q;
    assign bus.splash   = in_splash;
    assign bus.vga_data = vga_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: directed stimulus queues expected values stamped with
// the clock cycle they apply to; a negedge monitor pops and compares them against the DUT.
module tb_game_flow_ctrl;
    import game_pkg::*;

    localparam logic [11:0] BG     = 12'hA6C;
    localparam logic [11:0] BG_DIM = 12'h536;

    localparam int K_STATE  = 0;
    localparam int K_LIVES  = 1;
    localparam int K_LEVEL  = 2;
    localparam int K_SPLASH = 3;
    localparam int K_VGA    = 4;

    typedef struct {
        int          when;
        int          kind;
        logic [11:0] exp;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_err;
    exp_t sb[$];

    game_flow_ctrl_if bus ();

    game_flow_ctrl #(
        .LIVES         (3),
        .LEVELS        (4),
        .SPLASH_FRAMES (120),
        .BLINK_FRAMES  (8)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: compares every queued expectation that falls due in the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].when <= cyc) begin
            exp_t        e;
            logic [11:0] act;
            e = sb.pop_front();
            case (e.kind)
                K_STATE:  act = {9'b0, bus.state};
                K_LIVES:  act = {8'b0, bus.lives};
                K_LEVEL:  act = {8'b0, bus.level};
                K_SPLASH: act = {11'b0, bus.splash};
                default:  act = bus.vga_data;
            endcase
            n_checks++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(int kind, logic [11:0] v, string name);
        exp_t e;
        e.when = cyc;
        e.kind = kind;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic chk_all(game_state_e st, int lv, int lvl, logic sp, string name);
        chk(K_STATE,  12'(st),  {name, ".state"});
        chk(K_LIVES,  12'(lv),  {name, ".lives"});
        chk(K_LEVEL,  12'(lvl), {name, ".level"});
        chk(K_SPLASH, 12'(sp),  {name, ".splash"});
    endtask

    task automatic ticks(int n);
        bus.frame_tick = 1'b1;
        repeat (n) step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic pulse_die();
        bus.die = 1'b1; step(); bus.die = 1'b0;
    endtask

    task automatic pulse_done();
        bus.level_done = 1'b1; step(); bus.level_done = 1'b0;
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1; step(); bus.restart = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; step(); bus.start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.restart    = 1'b0;
        bus.die        = 1'b0;
        bus.level_done = 1'b0;
        bus.pause_btn  = 1'b0;
        bus.bg_color   = BG;

        // Reset values while reset is still asserted
        step(); step();
        chk_all(INITIAL, 3, 0, 1'b0, "reset");
        chk(K_VGA, 12'h000, "reset.vga");
        rst_n = 1'b1;
        step();
        chk(K_VGA, 12'hF00, "initial.vga");

        // 1: start, vga follows one cycle later
        pulse_start();
        chk_all(RUNNING, 3, 0, 1'b0, "start");
        chk(K_VGA, 12'hF00, "start.vga_lag");
        step();
        chk(K_VGA, BG, "running.vga");

        // 2: die, blink and full splash
        pulse_die();
        chk_all(DYING, 2, 0, 1'b1, "die1");
        step();
        chk(K_VGA, BG, "dying.blink0");
        ticks(8); step();
        chk(K_VGA, 12'hFFF, "dying.blink1");
        ticks(8); step();
        chk(K_VGA, BG, "dying.blink0b");
        ticks(103);
        chk(K_STATE, 12'(DYING), "splash119.state");
        ticks(1);
        chk_all(RUNNING, 2, 0, 1'b0, "splash120");

        // 3: run out of lives
        pulse_die();
        chk_all(DYING, 1, 0, 1'b1, "die2");
        ticks(120);
        chk(K_STATE, 12'(RUNNING), "die2.exit");
        pulse_die();
        chk_all(OVER, 0, 0, 1'b0, "die3");
        step();
        chk(K_VGA, 12'h000, "over.vga");
        pulse_die();
        chk(K_LIVES, 12'd0, "over.no_underflow");
        pulse_done();
        chk(K_STATE, 12'(OVER), "over.done_ignored");
        pulse_start();
        chk(K_STATE, 12'(OVER), "over.start_ignored");
        pulse_restart();
        chk_all(INITIAL, 3, 0, 1'b0, "restart_over");

        // 4: climb all levels to SUCCESS
        pulse_start();
        pulse_done();
        chk_all(LEVEL_UP, 3, 1, 1'b1, "lvl1");
        step();
        chk(K_VGA, 12'h0F0, "levelup.vga");
        ticks(120);
        chk(K_STATE, 12'(RUNNING), "lvl1.exit");
        pulse_done();
        chk(K_LEVEL, 12'd2, "lvl2");
        ticks(120);
        pulse_done();
        chk(K_LEVEL, 12'd3, "lvl3");
        ticks(120);
        pulse_done();
        chk_all(SUCCESS, 3, 3, 1'b0, "success");
        step();
        chk(K_VGA, 12'h00F, "success.vga");
        pulse_done();
        chk(K_LEVEL, 12'd3, "success.level_hold");

        // 5: priority and restart mid-splash
        pulse_restart();
        pulse_start();
        bus.die = 1'b1; bus.level_done = 1'b1; step();
        bus.die = 1'b0; bus.level_done = 1'b0;
        chk_all(DYING, 2, 0, 1'b1, "die_over_done");
        ticks(120);
        pulse_done();
        chk(K_STATE, 12'(LEVEL_UP), "lvlup_mid");
        ticks(50);
        pulse_restart();
        chk_all(INITIAL, 3, 0, 1'b0, "restart_mid_splash");
        pulse_start();
        bus.die = 1'b1; bus.restart = 1'b1; step();
        bus.die = 1'b0; bus.restart = 1'b0;
        chk_all(INITIAL, 3, 0, 1'b0, "restart_over_die");
        pulse_start();
        pulse_done();
        ticks(119);
        chk(K_STATE, 12'(LEVEL_UP), "splash_cleared.119");
        ticks(1);
        chk(K_STATE, 12'(RUNNING), "splash_cleared.120");

        // 6: pause
        bus.pause_btn = 1'b1; step(); bus.pause_btn = 1'b0;
`ifdef GAME_PAUSE_EN
        chk(K_STATE, 12'(PAUSED), "pause.enter");
        step();
        chk(K_VGA, BG_DIM, "pause.vga");
        pulse_die();
        chk_all(PAUSED, 3, 1, 1'b0, "pause.die_ignored");
        bus.pause_btn = 1'b1; step(); bus.pause_btn = 1'b0;
        chk(K_STATE, 12'(RUNNING), "pause.exit");
`else
        chk_all(RUNNING, 3, 1, 1'b0, "pause.ignored");
        step();
        chk(K_VGA, BG, "pause.ignored.vga");
`endif

        step(); step();
        n_checks++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
